nibble_logger: RTL and testbench

Downstream capture-and-serialise stage for a 4-bit logic-demo output bus. Samples the 4-bit value every clock, queues each change in a small FIFO, and serialises queued nibbles onto a single-wire, UART-style TX line, so the demo's activity can be observed through one output pin. Sits directly after the demo core, on the same clock and reset.

---
 rtl/nibble_logger.sv | 217 +++++++++++++++++++++
 tb/tb_nibble_logger.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_logger.sv
// rtl/nibble_logger.sv - capture 4-bit bus changes into a FIFO and serialise them on a UART-style line
//
// Purpose:
//   Watches a 4-bit bus every clock. Each change seen while capture is
//   enabled is queued in a small circular FIFO. Queued nibbles go out on a
//   single wire as frames: start bit (0), d0..d3 LSB first, optional even
//   parity bit, stop bit (1). Every bit is held for DIV clocks.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 2)
//   DIV    clocks per serial bit (>= 1)
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   din      in   monitored nibble
//   en       in   capture enable
//   clr_ovf  in   synchronous clear of ovf
//   tx       out  serial output, idle high (registered)
//   busy     out  transmitter not idle (registered)
//   empty    out  FIFO empty (registered)
//   full     out  FIFO holds DEPTH entries (registered)
//   ovf      out  sticky: a change was dropped because the FIFO was full
//
// Build option:
//   NLOG_PARITY_EN  when defined, a PARITY bit (XOR of d0..d3) follows d3.

`timescale 1ns/1ps

module nibble_logger #(
  parameter int DEPTH = 8,
  parameter int DIV   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] din,
  input  logic       en,
  input  logic       clr_ovf,
  output logic       tx,
  output logic       busy,
  output logic       empty,
  output logic       full,
  output logic       ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [TW-1:0] TLAST = TW'(DIV - 1);
  localparam logic [CW-1:0] CFULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [3:0]    prev;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  state_t        state;
  logic [TW-1:0] timer;
  logic [1:0]    bitidx;
  logic [3:0]    data_q;

  logic push;
  logic pop;
  logic accept;
  logic drop;

  // Pop is decided from registered state only, so no input reaches an
  // output combinationally. A push into a full FIFO is still accepted when
  // the transmitter frees a slot on the same edge.
  always_comb begin
    push      = en && (din != prev);
    pop       = (state == S_IDLE) && !empty;
    accept    = push && (!full || pop);
    drop      = push && full && !pop;
    count_nxt = count;
    if (accept && !pop) begin
      count_nxt = count + CW'(1);
    end else if (pop && !accept) begin
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev   <= 4'h0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      prev <= din;
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CFULL);
      // A drop on the same edge as a clear request keeps the flag set.
      if (drop) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= din;
    end
  end

  // Transmitter. tx and busy are registered alongside the state so each
  // bit level appears on the edge that enters it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      timer  <= '0;
      bitidx <= 2'd0;
      data_q <= 4'h0;
      tx     <= 1'b1;
      busy   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          tx    <= 1'b1;
          timer <= '0;
          if (pop) begin
            data_q <= mem[rd_ptr];
            state  <= S_START;
            tx     <= 1'b0;
            busy   <= 1'b1;
          end
        end

        S_START: begin
          if (timer == TLAST) begin
            state  <= S_DATA;
            tx     <= data_q[0];
            bitidx <= 2'd0;
            timer  <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_DATA: begin
          if (timer == TLAST) begin
            timer <= '0;
            if (bitidx == 2'd3) begin
`ifdef NLOG_PARITY_EN
              state <= S_PARITY;
              tx    <= ^data_q;
`else
              state <= S_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bitidx <= bitidx + 2'd1;
              tx     <= data_q[bitidx + 2'd1];
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

`ifdef NLOG_PARITY_EN
        S_PARITY: begin
          if (timer == TLAST) begin
            state <= S_STOP;
            tx    <= 1'b1;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
`endif

        S_STOP: begin
          if (timer == TLAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            tx    <= 1'b1;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          tx    <= 1'b1;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_logger.sv
// tb/tb_nibble_logger.sv - randomized self-checking bench for nibble_logger against a frame-schedule model

`timescale 1ns/1ps

module tb_nibble_logger;

  localparam int DEPTH = 8;
  localparam int DIV   = 4;
`ifdef NLOG_PARITY_EN
  localparam int NBITS = 7;
`else
  localparam int NBITS = 6;
`endif
  localparam int FLEN = NBITS * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] din = 4'h0;
  logic       en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       tx;
  logic       busy;
  logic       empty;
  logic       full;
  logic       ovf;

  nibble_logger #(.DEPTH(DEPTH), .DIV(DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .en      (en),
    .clr_ovf (clr_ovf),
    .tx      (tx),
    .busy    (busy),
    .empty   (empty),
    .full    (full),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a queue of accepted nibbles plus a schedule of frames.
  // A frame popped at edge n occupies edges n..n+FLEN-1; the next pop can
  // happen no earlier than edge n+FLEN+1.
  logic [3:0]       m_q[$];
  logic [3:0]       m_prev;
  logic             m_ovf;
  int               m_edge;
  int               m_next_pop;
  int               m_fstart;
  logic [NBITS-1:0] m_bits;

  task automatic model_reset();
    m_q.delete();
    m_prev     = 4'h0;
    m_ovf      = 1'b0;
    m_edge     = 0;
    m_next_pop = 0;
    m_fstart   = -1000000;
    m_bits     = '1;
  endtask

  task automatic model_edge(input logic [3:0] d, input logic e, input logic c);
    logic [3:0] h;
    bit         pushv;
    if (m_edge >= m_next_pop && m_q.size() > 0) begin
      h          = m_q.pop_front();
      m_fstart   = m_edge;
      m_next_pop = m_edge + FLEN + 1;
      m_bits     = '1;
      m_bits[0]  = 1'b0;
      for (int i = 0; i < 4; i++) m_bits[1 + i] = h[i];
`ifdef NLOG_PARITY_EN
      m_bits[5]  = h[0] ^ h[1] ^ h[2] ^ h[3];
`endif
    end
    pushv  = e && (d != m_prev);
    m_prev = d;
    if (pushv && m_q.size() < DEPTH) begin
      m_q.push_back(d);
      if (c) m_ovf = 1'b0;
    end else if (pushv) begin
      m_ovf = 1'b1;
    end else if (c) begin
      m_ovf = 1'b0;
    end
    m_edge++;
  endtask

  function automatic int frame_pos();
    return (m_edge - 1) - m_fstart;
  endfunction

  task automatic check_outputs();
    int  j;
    bit  act;
    logic exp_tx;
    j      = frame_pos();
    act    = (j >= 0) && (j < FLEN);
    exp_tx = act ? m_bits[j / DIV] : 1'b1;
    check_eq("tx", {31'd0, tx}, {31'd0, exp_tx});
    check_eq("busy", {31'd0, busy}, {31'd0, act});
    check_eq("empty", {31'd0, empty}, (m_q.size() == 0) ? 32'd1 : 32'd0);
    check_eq("full", {31'd0, full}, (m_q.size() == DEPTH) ? 32'd1 : 32'd0);
    check_eq("ovf", {31'd0, ovf}, {31'd0, m_ovf});
  endtask

  // Called about 1ns after an edge: drive, wait for the next edge, update
  // the model with what was sampled, then check 1ns later.
  task automatic step(input logic [3:0] d, input logic e, input logic c);
    din     = d;
    en      = e;
    clr_ovf = c;
    @(posedge clk);
    model_edge(d, e, c);
    #1;
    check_outputs();
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(din, en, 1'b0);
  endtask

  initial begin
    logic [3:0] v;
    logic [3:0] d;
    logic       e;
    logic       c;
    bit         reached;

    // Reset held with the clock running.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx", {31'd0, tx}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_empty", {31'd0, empty}, 32'd1);
    check_eq("rst_full", {31'd0, full}, 32'd0);
    check_eq("rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Idle with din at its reset value: no frame.
    for (int i = 0; i < 50; i++) step(4'h0, 1'b1, 1'b0);

    // Single frame of 5.
    step(4'h5, 1'b1, 1'b0);
    hold(30);

    // Capture disabled while the bus moves.
    step(4'h1, 1'b0, 1'b0);
    step(4'h2, 1'b0, 1'b0);
    step(4'h3, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) step(4'h3, 1'b1, 1'b0);

    // Overflow: ten distinct values on consecutive edges, clear requested
    // together with the dropping push, then alone.
    v = din;
    for (int i = 0; i < 9; i++) begin
      v = v + 4'h1;
      step(v, 1'b1, 1'b0);
    end
    check_eq("ovf_full", {31'd0, full}, 32'd1);
    v = v + 4'h1;
    step(v, 1'b1, 1'b1);
    check_eq("ovf_set_wins", {31'd0, ovf}, 32'd1);
    step(v, 1'b1, 1'b1);
    check_eq("ovf_cleared", {31'd0, ovf}, 32'd0);
    hold(9 * (FLEN + 1) + 10);

    // Randomized traffic at a few change rates.
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 800; i++) begin
        d = ($urandom_range(0, (blk == 2) ? 2 : 30) == 0) ? 4'($urandom_range(0, 15)) : din;
        e = ($urandom_range(0, 9) != 0);
        c = ($urandom_range(0, 15) == 0);
        step(d, e, c);
      end
    end
    hold(DEPTH * (FLEN + 1) + 10);

    // Reset in the middle of d2 of a frame carrying 7.
    if (din == 4'h7) step(4'h0, 1'b1, 1'b0);
    hold(FLEN + 2);
    step(4'h7, 1'b1, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      if (frame_pos() >= 3 * DIV && frame_pos() < 4 * DIV) reached = 1'b1;
      else step(4'h7, 1'b1, 1'b0);
    end
    check_eq("midframe_reach", {31'd0, reached}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_tx", {31'd0, tx}, 32'd1);
    check_eq("async_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("async_rst_empty", {31'd0, empty}, 32'd1);
    din = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 60; i++) step(4'h0, 1'b1, 1'b0);

    // Frame of 7 runs to completion (parity 1 in the parity build).
    step(4'h7, 1'b1, 1'b0);
    hold(FLEN + 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
